// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: opcode encodings, ALU operation select and
// the microinstruction (control word) layout driven by the control unit.
package arch_defs_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_t;

    // ALU_ADD is encoded as 0 so an idle word is all-zero.
    typedef struct packed {
        logic    oe_pc;
        logic    oe_ram;
        logic    oe_ir;
        logic    oe_a;
        logic    oe_alu;
        logic    load_mar;
        logic    load_ir;
        logic    load_a;
        logic    load_b;
        logic    load_ram;
        logic    load_pc;
        logic    load_o;
        logic    load_flags;
        logic    pc_enable;
        alu_op_t alu_op;
    } control_word_t;

    localparam int unsigned NUM_STEPS = 7;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: maps (step, opcode, flags) to one control word.
// Steps 0-2 are the shared fetch; any step code above 5 decodes to idle.
module microcode_rom
    import arch_defs_pkg::*;
(
    input  logic [2:0]    step,
    input  logic [3:0]    opcode,
    input  logic          flag_zero,
    input  logic          flag_carry,
    output control_word_t cw
);

    always_comb begin
        cw = '0;
        case (step)
            3'd0: begin
                cw.oe_pc    = 1'b1;
                cw.load_mar = 1'b1;
            end
            3'd1: begin
                cw.oe_ram  = 1'b1;
                cw.load_ir = 1'b1;
            end
            3'd2: cw.pc_enable = 1'b1;
            3'd3: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw.oe_ir    = 1'b1;
                        cw.load_mar = 1'b1;
                    end
                    OP_LDI: begin
                        cw.oe_ir  = 1'b1;
                        cw.load_a = 1'b1;
                    end
                    OP_JMP: begin
                        cw.oe_ir   = 1'b1;
                        cw.load_pc = 1'b1;
                    end
                    // Conditional jumps leave the whole word idle when not taken.
                    OP_JC: begin
                        cw.oe_ir   = flag_carry;
                        cw.load_pc = flag_carry;
                    end
                    OP_JZ: begin
                        cw.oe_ir   = flag_zero;
                        cw.load_pc = flag_zero;
                    end
                    OP_OUT: begin
                        cw.oe_a   = 1'b1;
                        cw.load_o = 1'b1;
                    end
                    default: ;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_LDA: begin
                        cw.oe_ram = 1'b1;
                        cw.load_a = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw.oe_ram = 1'b1;
                        cw.load_b = 1'b1;
                    end
                    OP_STA: begin
                        cw.oe_a     = 1'b1;
                        cw.load_ram = 1'b1;
                    end
                    default: ;
                endcase
            end
            3'd5: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw.alu_op     = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
                    cw.oe_alu     = 1'b1;
                    cw.load_a     = 1'b1;
                    cw.load_flags = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fixed T0..T6 step ring with a sticky HALT state,
// driving the microcode ROM and masking its output during reset and HALT.
module control_unit
    import arch_defs_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    opcode,
    input  logic          flag_zero,
    input  logic          flag_carry,
    output control_word_t control_word,
    output logic          halted
);

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        T6   = 3'd6,
        HALT = 3'd7
    } step_t;

    step_t         state_q;
    step_t         state_d;
    control_word_t rom_cw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HALT: state_d = HALT;
            T6:   state_d = T0;
            T3:   state_d = (opcode == OP_HLT) ? HALT : T4;
            default: state_d = step_t'(state_q + 3'd1);
        endcase
    end

    microcode_rom u_microcode_rom (
        .step       (state_q),
        .opcode     (opcode),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .cw         (rom_cw)
    );

    // Reset takes priority so a halted machine shows halted=0 while reset is held.
    always_comb begin
        control_word = rom_cw;
        halted       = 1'b0;
        if (reset) begin
            control_word = '0;
        end else if (state_q == HALT) begin
            control_word = '0;
            halted       = 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-step microinstruction checks for every
// instruction class, conditional jumps, HALT, reset recovery and a random sweep.
module tb_control_unit;
    import arch_defs_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    opcode = 4'h0;
    logic          flag_zero = 1'b0;
    logic          flag_carry = 1'b0;
    control_word_t control_word;
    logic          halted;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
        .control_word (control_word),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef enum int {
        U_IDLE, U_F0, U_F1, U_F2, U_IR_MAR, U_RAM_A, U_RAM_B,
        U_ALU_ADD, U_ALU_SUB, U_A_RAM, U_IR_A, U_IR_PC, U_A_O
    } uop_e;

    function automatic control_word_t uop(input uop_e u);
        control_word_t c;
        c = '0;
        case (u)
            U_F0:      begin c.oe_pc = 1'b1;  c.load_mar = 1'b1; end
            U_F1:      begin c.oe_ram = 1'b1; c.load_ir = 1'b1; end
            U_F2:      c.pc_enable = 1'b1;
            U_IR_MAR:  begin c.oe_ir = 1'b1;  c.load_mar = 1'b1; end
            U_RAM_A:   begin c.oe_ram = 1'b1; c.load_a = 1'b1; end
            U_RAM_B:   begin c.oe_ram = 1'b1; c.load_b = 1'b1; end
            U_ALU_ADD: begin c.oe_alu = 1'b1; c.load_a = 1'b1; c.load_flags = 1'b1; c.alu_op = ALU_ADD; end
            U_ALU_SUB: begin c.oe_alu = 1'b1; c.load_a = 1'b1; c.load_flags = 1'b1; c.alu_op = ALU_SUB; end
            U_A_RAM:   begin c.oe_a = 1'b1;   c.load_ram = 1'b1; end
            U_IR_A:    begin c.oe_ir = 1'b1;  c.load_a = 1'b1; end
            U_IR_PC:   begin c.oe_ir = 1'b1;  c.load_pc = 1'b1; end
            U_A_O:     begin c.oe_a = 1'b1;   c.load_o = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (control_word !== '0) begin
            errors++;
            $display("FAIL reset_cw got %h want 0", control_word);
        end
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_halted got %b want 0", halted);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (control_word !== uop(U_F0)) begin
            errors++;
            $display("FAIL reset_first_t0 got %h want %h", control_word, uop(U_F0));
        end
    endtask

    task automatic test_fetch_ldi();
        uop_e exp [7] = '{U_F0, U_F1, U_F2, U_IR_A, U_IDLE, U_IDLE, U_IDLE};
        do_reset();
        opcode = OP_LDI;
        for (int s = 0; s < 7; s++) begin
            #1;
            checks++;
            if (control_word !== uop(exp[s])) begin
                errors++;
                $display("FAIL ldi_t%0d got %h want %h", s, control_word, uop(exp[s]));
            end
            tick();
        end
        #1;
        checks++;
        if (control_word !== uop(U_F0)) begin
            errors++;
            $display("FAIL ldi_wrap got %h want %h", control_word, uop(U_F0));
        end
    endtask

    // Back-to-back instructions without reset exercise the T6->T0 wrap.
    task automatic test_back_to_back();
        logic [3:0] ops [13] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hE,
                                 4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD};
        uop_e t3 [13] = '{U_IR_MAR, U_IR_MAR, U_IR_MAR, U_IR_MAR, U_IR_A, U_IR_PC, U_A_O,
                          U_IDLE, U_IDLE, U_IDLE, U_IDLE, U_IDLE, U_IDLE};
        uop_e t4 [13] = '{U_RAM_A, U_RAM_B, U_RAM_B, U_A_RAM, U_IDLE, U_IDLE, U_IDLE,
                          U_IDLE, U_IDLE, U_IDLE, U_IDLE, U_IDLE, U_IDLE};
        uop_e t5 [13] = '{U_IDLE, U_ALU_ADD, U_ALU_SUB, U_IDLE, U_IDLE, U_IDLE, U_IDLE,
                          U_IDLE, U_IDLE, U_IDLE, U_IDLE, U_IDLE, U_IDLE};
        uop_e exp;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            opcode = ops[i];
            for (int s = 0; s < 7; s++) begin
                case (s)
                    0: exp = U_F0;
                    1: exp = U_F1;
                    2: exp = U_F2;
                    3: exp = t3[i];
                    4: exp = t4[i];
                    5: exp = t5[i];
                    default: exp = U_IDLE;
                endcase
                flag_zero  = s[0];
                flag_carry = s[1];
                #1;
                checks++;
                if (control_word !== uop(exp)) begin
                    errors++;
                    $display("FAIL b2b_op%h_t%0d got %h want %h", ops[i], s, control_word, uop(exp));
                end
                tick();
            end
        end
    endtask

    task automatic test_cond_jumps();
        // {opcode, carry at T3, zero at T3, taken}
        logic [3:0] op   [4] = '{4'h7, 4'h7, 4'h8, 4'h8};
        logic       c_t3 [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       z_t3 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       take [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        control_word_t exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            opcode = op[i];
            for (int s = 0; s < 7; s++) begin
                // Off-T3 flags are the opposite of T3 flags; they must not matter.
                flag_carry = (s == 3) ? c_t3[i] : ~c_t3[i];
                flag_zero  = (s == 3) ? z_t3[i] : ~z_t3[i];
                case (s)
                    0: exp = uop(U_F0);
                    1: exp = uop(U_F1);
                    2: exp = uop(U_F2);
                    3: exp = take[i] ? uop(U_IR_PC) : uop(U_IDLE);
                    default: exp = uop(U_IDLE);
                endcase
                #1;
                checks++;
                if (control_word !== exp) begin
                    errors++;
                    $display("FAIL jump%0d_op%h_t%0d got %h want %h", i, op[i], s, control_word, exp);
                end
                tick();
            end
        end
    endtask

    task automatic test_hlt();
        uop_e exp [4] = '{U_F0, U_F1, U_F2, U_IDLE};
        do_reset();
        opcode = OP_HLT;
        for (int s = 0; s < 4; s++) begin
            #1;
            checks++;
            if (control_word !== uop(exp[s]) || halted !== 1'b0) begin
                errors++;
                $display("FAIL hlt_t%0d got %h/%b want %h/0", s, control_word, halted, uop(exp[s]));
            end
            tick();
        end
        for (int c = 0; c < 50; c++) begin
            opcode     = 4'(c);
            flag_carry = c[0];
            flag_zero  = c[1];
            #1;
            checks++;
            if (control_word !== '0 || halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold_c%0d got %h/%b want 0/1", c, control_word, halted);
            end
            tick();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (control_word !== '0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset_during got %h/%b want 0/0", control_word, halted);
        end
        tick();
        reset  = 1'b0;
        opcode = OP_NOP;
        #1;
        checks++;
        if (control_word !== uop(U_F0) || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset_after got %h/%b want %h/0", control_word, halted, uop(U_F0));
        end
    endtask

    task automatic test_reset_mid_add();
        uop_e pre  [4] = '{U_F0, U_F1, U_F2, U_IR_MAR};
        uop_e full [7] = '{U_F0, U_F1, U_F2, U_IR_MAR, U_RAM_B, U_ALU_ADD, U_IDLE};
        do_reset();
        opcode = OP_ADD;
        for (int s = 0; s < 4; s++) begin
            #1;
            checks++;
            if (control_word !== uop(pre[s])) begin
                errors++;
                $display("FAIL addrst_t%0d got %h want %h", s, control_word, uop(pre[s]));
            end
            tick();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (control_word !== '0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL addrst_t4_reset got %h/%b want 0/0", control_word, halted);
        end
        tick();
        reset = 1'b0;
        for (int s = 0; s < 7; s++) begin
            #1;
            checks++;
            if (control_word !== uop(full[s])) begin
                errors++;
                $display("FAIL addrst_after_t%0d got %h want %h", s, control_word, uop(full[s]));
            end
            tick();
        end
    endtask

    task automatic test_random_sweep();
        logic [3:0] op;
        int         oes;
        logic       stop;
        do_reset();
        for (int n = 0; n < 1000; n++) begin
            op   = 4'($urandom_range(0, 15));
            stop = 1'b0;
            opcode = op;
            for (int s = 0; s < 7 && !stop; s++) begin
                flag_carry = 1'($urandom_range(0, 1));
                flag_zero  = 1'($urandom_range(0, 1));
                #1;
                oes = int'(control_word.oe_pc) + int'(control_word.oe_ram) + int'(control_word.oe_ir)
                    + int'(control_word.oe_a) + int'(control_word.oe_alu);
                checks++;
                if (oes > 1) begin
                    errors++;
                    $display("FAIL sweep_onehot op%h t%0d got %0d oe want <=1", op, s, oes);
                end
                if (s < 3) begin
                    checks++;
                    if (control_word !== uop(s == 0 ? U_F0 : (s == 1 ? U_F1 : U_F2))) begin
                        errors++;
                        $display("FAIL sweep_fetch op%h t%0d got %h", op, s, control_word);
                    end
                end else if (op == 4'h0 || (op >= 4'h9 && op <= 4'hD) || op == 4'hF) begin
                    checks++;
                    if (control_word !== '0) begin
                        errors++;
                        $display("FAIL sweep_idle op%h t%0d got %h want 0", op, s, control_word);
                    end
                end
                tick();
                if (op == 4'hF && s == 3) begin
                    checks++;
                    if (halted !== 1'b1 || control_word !== '0) begin
                        errors++;
                        $display("FAIL sweep_halt got %h/%b want 0/1", control_word, halted);
                    end
                    do_reset();
                    stop = 1'b1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_ldi();
        test_back_to_back();
        test_cond_jumps();
        test_hlt();
        test_reset_mid_add();
        test_random_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
